// File: rtl/dct_reload_timer_pkg.sv
`default_nettype none
// ============================================================================
// dct_reload_timer_pkg : shared state and mode encodings for the reload timer
// Revision: 1.0
// ============================================================================
package dct_reload_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_RELOAD  = 1'b1;

endpackage : dct_reload_timer_pkg
`default_nettype wire

// File: rtl/dct_readback_latch.sv
`default_nettype none
// ============================================================================
// dct_readback_latch : snapshot register capturing the live count for readback
// Revision: 1.0
// ============================================================================
module dct_readback_latch
   import dct_reload_timer_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             latch_i,
   input  logic [WIDTH-1:0] cnt_i,
   output logic [WIDTH-1:0] ol_o
);

   logic [WIDTH-1:0] ol_q;
   logic [WIDTH-1:0] ol_d;

   always_comb begin
      ol_d = ol_q;
      if (latch_i) begin
         ol_d = cnt_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ol_q <= '0;
      end else begin
         ol_q <= ol_d;
      end
   end

   assign ol_o = ol_q;

endmodule : dct_readback_latch
`default_nettype wire

// File: rtl/dct_reload_timer.sv
`default_nettype none
// ============================================================================
// dct_reload_timer : presettable cascadable down-counter, one-shot/auto-reload
// Revision: 1.0
// ============================================================================
module dct_reload_timer
   import dct_reload_timer_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             C,
   input  logic             notR,
   input  logic [WIDTH-1:0] D,
   input  logic             notEWR,
   input  logic             E1,
   input  logic             E2,
   input  logic             MODE,
   input  logic             LATCH,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] OL,
   output logic             BR,
   output logic             RUN
);

   localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] rl_q;
   logic [WIDTH-1:0] rl_d;
   logic             br_q;
   logic             br_d;
   logic             w_count;
   logic             w_tc;

   assign w_count = (state_q == ST_ARMED) && E1 && E2;
   assign w_tc    = (cnt_q == c_one);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rl_d    = rl_q;
      br_d    = 1'b0;
      if (!notEWR) begin
         cnt_d   = D;
         rl_d    = D;
         state_d = ST_ARMED;
      end else if (w_count) begin
         if (w_tc) begin
            br_d = 1'b1;
            if (MODE == MODE_RELOAD) begin
               cnt_d = rl_q;
            end else begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end
         end else begin
            // A preload of 0 wraps to all-ones here, giving a 2^WIDTH period.
            cnt_d = cnt_q - c_one;
         end
      end
   end

   always_ff @(posedge C or negedge notR) begin
      if (!notR) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rl_q    <= '0;
         br_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rl_q    <= rl_d;
         br_q    <= br_d;
      end
   end

   dct_readback_latch #(
      .WIDTH (WIDTH)
   ) u_readback (
      .clk_i   (C),
      .rst_ni  (notR),
      .latch_i (LATCH),
      .cnt_i   (cnt_q),
      .ol_o    (OL)
   );

   assign Q   = cnt_q;
   assign BR  = br_q;
   assign RUN = (state_q == ST_ARMED);

endmodule : dct_reload_timer
`default_nettype wire

// File: tb/tb_dct_reload_timer.sv
`default_nettype none
// ============================================================================
// tb_dct_reload_timer : directed bench with a scoreboard of expected outputs
// Revision: 1.0
// ============================================================================
module tb_dct_reload_timer;

   localparam int W = 4;

   typedef struct packed {
      logic [W-1:0] q;
      logic         br;
      logic         run;
      logic [W-1:0] ol;
   } exp_t;

   logic         C = 1'b0;
   logic         notR = 1'b0;
   logic [W-1:0] D = '0;
   logic         notEWR = 1'b1;
   logic         E1 = 1'b1;
   logic         E2 = 1'b1;
   logic         MODE = 1'b0;
   logic         LATCH = 1'b0;
   logic [W-1:0] Q;
   logic [W-1:0] OL;
   logic         BR;
   logic         RUN;

   logic [W-1:0] s_D = '0;
   logic         s_notEWR = 1'b1;
   logic [W-1:0] q0, ol0, q1, ol1;
   logic         br0, br1, run0, run1;

   int checks = 0;
   int errors = 0;
   int brs    = 0;
   exp_t sb[$];

   // reference model of the timer, in terms of spec states
   logic [W-1:0] m_q = '0, m_rl = '0, m_ol = '0;
   logic         m_br = 1'b0;
   int           m_st = 0;   // 0 idle, 1 armed, 2 done

   always #5 C = ~C;

   dct_reload_timer #(.WIDTH(W)) dut (
      .C(C), .notR(notR), .D(D), .notEWR(notEWR), .E1(E1), .E2(E2),
      .MODE(MODE), .LATCH(LATCH), .Q(Q), .OL(OL), .BR(BR), .RUN(RUN)
   );

   dct_reload_timer #(.WIDTH(W)) u_s0 (
      .C(C), .notR(notR), .D(s_D), .notEWR(s_notEWR), .E1(1'b1), .E2(1'b1),
      .MODE(1'b1), .LATCH(1'b0), .Q(q0), .OL(ol0), .BR(br0), .RUN(run0)
   );

   dct_reload_timer #(.WIDTH(W)) u_s1 (
      .C(C), .notR(notR), .D(s_D), .notEWR(s_notEWR), .E1(br0), .E2(1'b1),
      .MODE(1'b1), .LATCH(1'b0), .Q(q1), .OL(ol1), .BR(br1), .RUN(run1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q = '0; m_rl = '0; m_ol = '0; m_br = 1'b0; m_st = 0;
   endtask

   // advance the model across one rising edge using the current inputs
   task automatic model_step();
      exp_t e;
      if (!notR) begin
         model_reset();
      end else begin
         if (LATCH) m_ol = m_q;
         if (!notEWR) begin
            m_q = D; m_rl = D; m_br = 1'b0; m_st = 1;
         end else if (m_st == 1 && E1 && E2) begin
            if (m_q == W'(1)) begin
               m_br = 1'b1;
               if (MODE) m_q = m_rl;
               else begin m_q = '0; m_st = 2; end
            end else begin
               m_q = m_q - W'(1);
               m_br = 1'b0;
            end
         end else begin
            m_br = 1'b0;
         end
      end
      e.q = m_q; e.br = m_br; e.run = (m_st == 1); e.ol = m_ol;
      sb.push_back(e);
   endtask

   task automatic cyc();
      exp_t e;
      model_step();
      @(posedge C);
      #1;
      e = sb.pop_front();
      check("Q", 32'(Q), 32'(e.q));
      check("BR", 32'(BR), 32'(e.br));
      check("RUN", 32'(RUN), 32'(e.run));
      check("OL", 32'(OL), 32'(e.ol));
      if (BR) brs++;
   endtask

   task automatic load(input logic [W-1:0] val, input logic mode);
      D = val; MODE = mode; notEWR = 1'b0;
      cyc();
      notEWR = 1'b1;
   endtask

   initial begin
      int t_first, t_gap, n_br0;

      // reset state
      #3;
      check("rst_Q", 32'(Q), 0);
      check("rst_OL", 32'(OL), 0);
      check("rst_BR", 32'(BR), 0);
      check("rst_RUN", 32'(RUN), 0);
      cyc();
      notR = 1'b1;
      cyc();

      // one-shot, preload 5
      load(4'd5, 1'b0);
      check("os_load_Q", 32'(Q), 5);
      check("os_load_RUN", 32'(RUN), 1);
      repeat (4) cyc();
      check("os_Q1", 32'(Q), 1);
      check("os_BR_before", 32'(BR), 0);
      cyc();
      check("os_Q0", 32'(Q), 0);
      check("os_BR", 32'(BR), 1);
      check("os_RUN", 32'(RUN), 0);
      brs = 0;
      repeat (10) cyc();
      check("os_hold_Q", 32'(Q), 0);
      check("os_hold_brs", 32'(brs), 0);

      // auto-reload, preload 3
      load(4'd3, 1'b1);
      brs = 0;
      repeat (9) cyc();
      check("ar_brs", 32'(brs), 3);
      check("ar_Q", 32'(Q), 3);
      check("ar_RUN", 32'(RUN), 1);

      // preload 0: full 2^WIDTH period
      load(4'd0, 1'b0);
      brs = 0;
      cyc();
      check("z_wrap_Q", 32'(Q), 15);
      check("z_wrap_BR", 32'(BR), 0);
      repeat (14) cyc();
      check("z_Q1", 32'(Q), 1);
      cyc();
      check("z_BR16", 32'(BR), 1);
      repeat (3) cyc();
      check("z_brs", 32'(brs), 1);

      // gating freezes the count
      load(4'd6, 1'b0);
      repeat (2) cyc();
      check("g_Q4", 32'(Q), 4);
      E2 = 1'b0;
      brs = 0;
      repeat (4) cyc();
      check("g_frozen", 32'(Q), 4);
      E2 = 1'b1;
      repeat (3) cyc();
      check("g_BR_early", 32'(brs), 0);
      cyc();
      check("g_BR4", 32'(BR), 1);

      // mid-count reload
      load(4'd5, 1'b0);
      repeat (3) cyc();
      check("rl_Q2", 32'(Q), 2);
      brs = 0;
      load(4'd9, 1'b0);
      check("rl_Q9", 32'(Q), 9);
      cyc();
      check("rl_brs", 32'(brs), 0);

      // readback snapshot at Q=7
      cyc();
      check("lt_Q7", 32'(Q), 7);
      LATCH = 1'b1;
      cyc();
      LATCH = 1'b0;
      repeat (3) cyc();
      check("lt_OL", 32'(OL), 7);
      check("lt_Q3", 32'(Q), 3);

      // reset dominates load and count
      load(4'd6, 1'b0);
      cyc();
      notR = 1'b0; notEWR = 1'b0; D = 4'd12;
      cyc();
      check("sim_Q", 32'(Q), 0);
      check("sim_RUN", 32'(RUN), 0);
      notR = 1'b1; notEWR = 1'b1;
      load(4'd8, 1'b0);
      cyc();
      #2 notR = 1'b0;
      #1;
      check("async_Q", 32'(Q), 0);
      check("async_RUN", 32'(RUN), 0);
      check("async_BR", 32'(BR), 0);
      check("async_OL", 32'(OL), 0);
      model_reset();
      cyc();
      notR = 1'b1;
      cyc();

      // cascade: stage-1 borrow period
      s_D = 4'd15; s_notEWR = 1'b0;
      @(posedge C); #1;
      s_notEWR = 1'b1;
      t_first = 0;
      for (int i = 1; i <= 600; i++) begin
         @(posedge C); #1;
         if (br1) begin t_first = i; break; end
      end
      check("cas_first", 32'(t_first), 226);
      t_gap = 0; n_br0 = 0;
      for (int i = 1; i <= 300; i++) begin
         @(posedge C); #1;
         if (br0) n_br0++;
         if (br1) begin t_gap = i; break; end
      end
      check("cas_period", 32'(t_gap), 225);
      check("cas_br0", 32'(n_br0), 15);
      @(posedge C); #1;
      check("cas_width", 32'(br1), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_dct_reload_timer
`default_nettype wire

// File: doc/dct_reload_timer.md
Name: dct_reload_timer

Overview:
- Presettable, cascadable down-counting timer; the decrementing counterpart of the team's 4-bit loadable up-counter.
- The CPU writes a preload value; the block counts down on enabled clocks and emits a one-cycle borrow pulse at terminal count.
- Operates in one-shot or auto-reload (divide-by-N) mode.
- Serves the interval-timer and baud-divider paths; the borrow of one stage feeds the enables of the next.

Parameters:
- WIDTH, 4, counter/preload width in bits (legal 2..16).

Ports:
- C  input  1  clock; all state changes on rising edge.
- notR  input  1  reset, asynchronous, active-low.
- D  input  WIDTH  preload data.
- notEWR  input  1  active-low load strobe, sampled on C.
- E1  input  1  count enable 1.
- E2  input  1  count enable 2; counting requires E1 & E2 (cascade input).
- MODE  input  1  0 = one-shot, 1 = auto-reload; sampled on C.
- LATCH  input  1  snapshot request for readback, sampled on C.
- Q  output  WIDTH  live count value.
- OL  output  WIDTH  latched count for CPU readback.
- BR  output  1  borrow/terminal-count pulse, registered, one cycle wide.
- RUN  output  1  high while counting is armed.

Behaviour:
- Reset (notR=0, asynchronous):
  - Q=0, OL=0, BR=0, RUN=0.
  - Reload register RL=0; state IDLE.
  - Dominates all other inputs, including a load or count in the same cycle.
- State machine (states IDLE, ARMED, DONE):
  - IDLE -> ARMED on load.
  - ARMED -> DONE on terminal count in one-shot mode.
  - ARMED stays ARMED on terminal count in auto-reload mode.
  - DONE -> ARMED on load.
  - RUN=1 exactly in ARMED.
- Priority at each edge: reset > load > count > hold.
- Load (notEWR=0):
  - Q<=D, RL<=D, BR<=0, state<=ARMED.
  - Allowed in any state; mid-count it restarts the count and cancels any pending BR.
- Count: only in ARMED with E1&E2=1. Otherwise Q, BR-source and state hold; BR is forced 0 every cycle without a terminal event.
- Terminal event is Q==1 while counting:
  - One-shot: Q<=0, BR<=1, state<=DONE.
  - Auto-reload: Q<=RL, BR<=1, stays ARMED.
  - Otherwise Q<=Q-1 modulo 2^WIDTH, BR<=0.
- Q==0 while ARMED (preload of 0):
  - Decrement wraps to all-ones, giving an effective period of 2^WIDTH.
  - No BR on the 0->max step.
- Period: with preload N (N>=1) and continuous enable, BR asserts on the edge N cycles after the load edge. In auto-reload, every N enabled cycles.
- Gating: dropping E1 or E2 freezes Q mid-count. Re-enabling resumes with no lost or extra step.
- MODE:
  - Sampled at each terminal event, so a change takes effect at the next terminal count.
  - In DONE, a MODE change does not restart counting.
- LATCH=1:
  - OL<=Q, using the pre-edge value of Q.
  - OL otherwise holds.
  - Independent of enables and state; a load in the same cycle does not affect the captured value.
- Arithmetic: unsigned, WIDTH bits, no carry-out other than BR.

Decomposition:
- Shared package: state encoding constants (IDLE/ARMED/DONE) and mode constants (MODE_ONESHOT=0, MODE_RELOAD=1), reused by the CPU-side timer decode.
- One natural sub-module: dct_readback_latch (LATCH/OL snapshot register). The counter core and FSM stay in the top module.

Test Plan:
- WIDTH=4, reset -> all outputs 0. Load D=5, MODE=0, E1=E2=1 -> Q: 5,4,3,2,1,0; BR=1 only on the 1->0 edge; RUN falls; Q holds 0 for 10 further cycles.
- MODE=1, load D=3, continuous enable -> Q cycles 3,2,1,3,2,1…; BR pulses every 3rd cycle; RUN stays 1.
- Load D=0, MODE=0 -> Q 0,15,14…1,0; BR once after 16 enabled cycles.
- Load D=6, toggle E2 low for 4 cycles at Q=4 -> Q frozen at 4, BR=0. Re-enable -> BR after exactly 4 more enabled cycles. Separately, reload D=9 when Q=2 -> Q=9, no BR.
- Simultaneous: notR low with notEWR low and count active -> Q=0, RUN=0. Reset asserted asynchronously mid-count (between edges) -> outputs clear immediately.
- LATCH at Q=7 while counting -> OL=7 and holds while Q continues. Two cascaded instances (BR of stage 0 into E1 of stage 1), both in reload mode with D=15 -> stage-1 BR every 225 clocks.
